// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl
// Multi-cycle sequencing controller for the MIPS datapath. Each instruction
// steps through fetch, decode, execute, memory and writeback states. The
// controller drives every datapath select and strobe, stalls on the memory
// ready handshake, traps illegal opcodes and stalled memory accesses, and
// counts retired instructions.
//
// Parameters:
//   TIMEOUT       consecutive mem_ready-low cycles tolerated in one memory
//                 state before faulting (0 disables the timeout)
//   CNT_W         width of the retired-instruction counter
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   opcode        IR[31:26], sampled in DECODE
//   mem_ready     memory completes the current access this cycle
//   pc_write      PC load enable
//   pc_write_cond PC load enable qualified by the ALU zero flag
//   ir_write      IR load enable
//   i_or_d        memory address select (0=PC, 1=ALUOut)
//   mem_read      memory read strobe
//   mem_write     memory write strobe
//   reg_dst       register-file write address select (1=rd)
//   reg_write     register-file write enable
//   mem_to_reg    register-file write data select (1=memory data)
//   alu_src_a     ALU operand A select (0=PC, 1=rs)
//   alu_src_b     ALU operand B select (00=rt, 01=4, 10=sext imm, 11=sext imm<<2)
//   alu_op        ALU operation (00=add, 01=sub, 10=funct)
//   pc_source     PC source select (00=ALU, 01=ALUOut, 10=jump target)
//   state         current FSM state encoding
//   instr_done    one-cycle retire pulse
//   retire_cnt    retired instruction count, wraps
//   fault         sticky fault flag
//   fault_code    01=illegal opcode, 10=memory timeout

module mips_mc_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             ir_write,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic [3:0]       state,
   output logic             instr_done,
   output logic [CNT_W-1:0] retire_cnt,
   output logic             fault,
   output logic [1:0]       fault_code
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC     = 4'd7,
      S_ALU_WB   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_FAULT    = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] CODE_ILLEGAL = 2'b01;
   localparam logic [1:0] CODE_TIMEOUT = 2'b10;

   // The wait counter only has to reach TIMEOUT-1; one spare bit keeps the
   // width legal when TIMEOUT is 0 or 1.
   localparam int                WAIT_W    = $clog2(TIMEOUT + 2);
   localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);

   state_t            state_q;
   state_t            state_d;
   logic [1:0]        code_d;
   logic              lw_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic              waiting;
   logic              timed_out;

   assign state = state_q;

   // A memory-facing state is stalling whenever mem_ready is low. The
   // timeout fires on the TIMEOUT-th consecutive stalled cycle, i.e. when
   // TIMEOUT-1 stalls have already been counted and this one is low too, so
   // a ready arriving on that cycle naturally wins.
   always_comb begin
      waiting   = 1'b0;
      timed_out = 1'b0;
      if ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR)) begin
         waiting = !mem_ready;
      end
      if ((TIMEOUT != 0) && waiting && (wait_cnt == WAIT_LAST)) begin
         timed_out = 1'b1;
      end
   end

   // Next-state logic. DECODE dispatches on the live opcode; MEM_ADDR uses
   // the lw/sw flag captured in DECODE because IR may not be stable later.
   // Any encoding outside the state set is treated like an illegal opcode.
   // A timeout overrides whatever the stalled state would have done.
   always_comb begin
      state_d = state_q;
      code_d  = 2'b00;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (mem_ready) begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               default: begin
                  state_d = S_FAULT;
                  code_d  = CODE_ILLEGAL;
               end
            endcase
         end
         S_MEM_ADDR: begin
            state_d = lw_q ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            if (mem_ready) begin
               state_d = S_MEM_WB;
            end
         end
         S_MEM_WR: begin
            if (mem_ready) begin
               state_d = S_FETCH;
            end
         end
         S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: begin
            state_d = S_FETCH;
         end
         S_EXEC: begin
            state_d = S_ALU_WB;
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_FAULT;
            code_d  = CODE_ILLEGAL;
         end
      endcase
      if (timed_out) begin
         state_d = S_FAULT;
         code_d  = CODE_TIMEOUT;
      end
   end

   // Datapath controls decode from the registered state. The only
   // exceptions are the FETCH load enables and the sw retire pulse, which
   // follow mem_ready combinationally so the access completes the same
   // cycle the memory answers.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      instr_done    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
         end
         S_MEM_WR: begin
            mem_write  = 1'b1;
            i_or_d     = 1'b1;
            instr_done = mem_ready;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_ALU_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            instr_done    = 1'b1;
         end
         S_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = 2'b10;
            instr_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // State register plus the lw/sw flag captured while the opcode is valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         lw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            lw_q <= (opcode == OP_LW);
         end
      end
   end

   // Stall counter. Every entry into a memory-facing state comes from a
   // different state, so clearing on any state change gives a fresh count
   // per access; it only advances on stalled cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (state_d != state_q) begin
         wait_cnt <= '0;
      end else if (waiting) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   // Retired-instruction counter, advancing on the same edge that ends the
   // retire cycle and wrapping naturally at the counter width.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_cnt <= '0;
      end else if (instr_done) begin
         retire_cnt <= retire_cnt + CNT_W'(1);
      end
   end

   // Fault flag and cause are captured once, on the edge that enters FAULT,
   // and then hold until reset since FAULT has no exit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault      <= 1'b0;
         fault_code <= 2'b00;
      end else if ((state_d == S_FAULT) && (state_q != S_FAULT)) begin
         fault      <= 1'b1;
         fault_code <= code_d;
      end
   end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl
// Self-checking bench for mips_mc_ctrl. A table of per-cycle vectors walks
// lw, R-type, beq, j, a stalled sw and an illegal opcode; hand-written
// sequences cover the FETCH timeout, ready on the last tolerated cycle,
// reset during MEM_RD and retire counter wrap (counter built 3 bits wide).

module tb_mips_mc_ctrl;

   localparam int TIMEOUT = 15;
   localparam int CNT_W   = 3;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   typedef struct {
      logic             rdy;
      logic [5:0]       op;
      logic [3:0]       st;
      logic [16:0]      ctl;
      logic [CNT_W-1:0] cnt;
      logic             flt;
      logic [1:0]       code;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic [5:0]       opcode;
   logic             mem_ready;
   logic             pc_write;
   logic             pc_write_cond;
   logic             ir_write;
   logic             i_or_d;
   logic             mem_read;
   logic             mem_write;
   logic             reg_dst;
   logic             reg_write;
   logic             mem_to_reg;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic [1:0]       pc_source;
   logic [3:0]       state;
   logic             instr_done;
   logic [CNT_W-1:0] retire_cnt;
   logic             fault;
   logic [1:0]       fault_code;

   logic [16:0] act_ctl;

   int total  = 0;
   int passed = 0;

   vec_t vecs[$];

   logic [16:0] C_ZERO, C_FETCH_R, C_FETCH_W, C_DEC, C_MADDR, C_MRD, C_MWB;
   logic [16:0] C_MWR_W, C_MWR_R, C_EXEC, C_AWB, C_BR, C_JMP;

   mips_mc_ctrl #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .ir_write      (ir_write),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .mem_to_reg    (mem_to_reg),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
      .state         (state),
      .instr_done    (instr_done),
      .retire_cnt    (retire_cnt),
      .fault         (fault),
      .fault_code    (fault_code)
   );

   // Observed control bundle, same bit order as mk() below.
   assign act_ctl = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                     reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                     pc_source, instr_done};

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends even if the bench stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [16:0] mk(input logic pcw, input logic pcwc, input logic irw,
                                      input logic iord, input logic mrd, input logic mwr,
                                      input logic rdst, input logic rw, input logic m2r,
                                      input logic asa, input logic [1:0] asb,
                                      input logic [1:0] aop, input logic [1:0] psrc,
                                      input logic done);
      return {pcw, pcwc, irw, iord, mrd, mwr, rdst, rw, m2r, asa, asb, aop, psrc, done};
   endfunction

   task automatic addVec(input logic rdy, input logic [5:0] op, input logic [3:0] st,
                         input logic [16:0] ctl, input logic [CNT_W-1:0] cnt,
                         input logic flt, input logic [1:0] code);
      vec_t v;
      v.rdy  = rdy;
      v.op   = op;
      v.st   = st;
      v.ctl  = ctl;
      v.cnt  = cnt;
      v.flt  = flt;
      v.code = code;
      vecs.push_back(v);
   endtask

   task automatic cmp(input string what, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         $display("[TB] FAIL %s: got %0h want %0h", what, got, want);
      end else begin
         passed++;
      end
   endtask

   // Drive inputs just after the falling edge and let them settle.
   task automatic applyStimulus(input logic rdy, input logic [5:0] op);
      mem_ready = rdy;
      opcode    = op;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] st, input logic [16:0] ctl,
                              input logic [CNT_W-1:0] cnt, input logic flt,
                              input logic [1:0] code);
      cmp({name, " state"},      32'(state),      32'(st));
      cmp({name, " ctl"},        32'(act_ctl),    32'(ctl));
      cmp({name, " retire_cnt"}, 32'(retire_cnt), 32'(cnt));
      cmp({name, " fault"},      32'(fault),      32'(flt));
      cmp({name, " fault_code"}, 32'(fault_code), 32'(code));
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      nextCycle();
      nextCycle();
      rst_n = 1'b1;
   endtask

   // FETCH stalls for 15 cycles; on the 15th either ready arrives (DECODE)
   // or the controller faults with a timeout.
   task automatic runFetchTimeout(input logic rdy_last);
      doReset();
      applyStimulus(L, OP_LW);
      checkOutput("to idle", 4'd0, C_ZERO, '0, L, 2'b00);
      nextCycle();
      for (int k = 1; k <= TIMEOUT; k++) begin
         if (k == TIMEOUT) begin
            applyStimulus(rdy_last, OP_LW);
            checkOutput("to last fetch", 4'd1, rdy_last ? C_FETCH_R : C_FETCH_W, '0, L, 2'b00);
         end else begin
            applyStimulus(L, OP_LW);
            checkOutput("to fetch wait", 4'd1, C_FETCH_W, '0, L, 2'b00);
         end
         nextCycle();
      end
      applyStimulus(H, OP_LW);
      if (rdy_last) begin
         checkOutput("to decode", 4'd2, C_DEC, '0, L, 2'b00);
      end else begin
         checkOutput("to fault", 4'd15, C_ZERO, '0, H, 2'b10);
         nextCycle();
         applyStimulus(H, OP_R);
         checkOutput("to fault hold", 4'd15, C_ZERO, '0, H, 2'b10);
      end
      nextCycle();
   endtask

   initial begin
      C_ZERO    = '0;
      C_FETCH_R = mk(H, L, H, L, H, L, L, L, L, L, 2'b01, 2'b00, 2'b00, L);
      C_FETCH_W = mk(L, L, L, L, H, L, L, L, L, L, 2'b01, 2'b00, 2'b00, L);
      C_DEC     = mk(L, L, L, L, L, L, L, L, L, L, 2'b11, 2'b00, 2'b00, L);
      C_MADDR   = mk(L, L, L, L, L, L, L, L, L, H, 2'b10, 2'b00, 2'b00, L);
      C_MRD     = mk(L, L, L, H, H, L, L, L, L, L, 2'b00, 2'b00, 2'b00, L);
      C_MWB     = mk(L, L, L, L, L, L, L, H, H, L, 2'b00, 2'b00, 2'b00, H);
      C_MWR_W   = mk(L, L, L, H, L, H, L, L, L, L, 2'b00, 2'b00, 2'b00, L);
      C_MWR_R   = mk(L, L, L, H, L, H, L, L, L, L, 2'b00, 2'b00, 2'b00, H);
      C_EXEC    = mk(L, L, L, L, L, L, L, L, L, H, 2'b00, 2'b10, 2'b00, L);
      C_AWB     = mk(L, L, L, L, L, L, H, H, L, L, 2'b00, 2'b00, 2'b00, H);
      C_BR      = mk(L, H, L, L, L, L, L, L, L, H, 2'b00, 2'b01, 2'b01, H);
      C_JMP     = mk(H, L, L, L, L, L, L, L, L, L, 2'b00, 2'b00, 2'b10, H);

      // lw (opcode changed to sw in MEM_ADDR to show the latched decision)
      addVec(H, OP_LW,   4'd0,  C_ZERO,    3'd0, L, 2'b00);
      addVec(H, OP_LW,   4'd1,  C_FETCH_R, 3'd0, L, 2'b00);
      addVec(H, OP_LW,   4'd2,  C_DEC,     3'd0, L, 2'b00);
      addVec(H, OP_SW,   4'd3,  C_MADDR,   3'd0, L, 2'b00);
      addVec(H, OP_SW,   4'd4,  C_MRD,     3'd0, L, 2'b00);
      addVec(H, OP_SW,   4'd5,  C_MWB,     3'd0, L, 2'b00);
      // R-type, beq, j
      addVec(H, OP_R,    4'd1,  C_FETCH_R, 3'd1, L, 2'b00);
      addVec(H, OP_R,    4'd2,  C_DEC,     3'd1, L, 2'b00);
      addVec(H, OP_R,    4'd7,  C_EXEC,    3'd1, L, 2'b00);
      addVec(H, OP_R,    4'd8,  C_AWB,     3'd1, L, 2'b00);
      addVec(H, OP_BEQ,  4'd1,  C_FETCH_R, 3'd2, L, 2'b00);
      addVec(H, OP_BEQ,  4'd2,  C_DEC,     3'd2, L, 2'b00);
      addVec(H, OP_BEQ,  4'd9,  C_BR,      3'd2, L, 2'b00);
      addVec(H, OP_J,    4'd1,  C_FETCH_R, 3'd3, L, 2'b00);
      addVec(H, OP_J,    4'd2,  C_DEC,     3'd3, L, 2'b00);
      addVec(H, OP_J,    4'd10, C_JMP,     3'd3, L, 2'b00);
      // sw with three stalled cycles in MEM_WR (opcode changed to lw in MEM_ADDR)
      addVec(H, OP_SW,   4'd1,  C_FETCH_R, 3'd4, L, 2'b00);
      addVec(H, OP_SW,   4'd2,  C_DEC,     3'd4, L, 2'b00);
      addVec(H, OP_LW,   4'd3,  C_MADDR,   3'd4, L, 2'b00);
      addVec(L, OP_LW,   4'd6,  C_MWR_W,   3'd4, L, 2'b00);
      addVec(L, OP_LW,   4'd6,  C_MWR_W,   3'd4, L, 2'b00);
      addVec(L, OP_LW,   4'd6,  C_MWR_W,   3'd4, L, 2'b00);
      addVec(H, OP_LW,   4'd6,  C_MWR_R,   3'd4, L, 2'b00);
      // illegal opcode traps and stays trapped
      addVec(H, OP_ADDI, 4'd1,  C_FETCH_R, 3'd5, L, 2'b00);
      addVec(H, OP_ADDI, 4'd2,  C_DEC,     3'd5, L, 2'b00);
      addVec(H, OP_ADDI, 4'd15, C_ZERO,    3'd5, H, 2'b01);
      addVec(L, OP_ADDI, 4'd15, C_ZERO,    3'd5, H, 2'b01);
      addVec(H, OP_LW,   4'd15, C_ZERO,    3'd5, H, 2'b01);
      addVec(H, OP_R,    4'd15, C_ZERO,    3'd5, H, 2'b01);

      rst_n     = 1'b0;
      mem_ready = 1'b0;
      opcode    = OP_R;
      nextCycle();
      nextCycle();
      #1;
      checkOutput("reset", 4'd0, C_ZERO, '0, L, 2'b00);
      nextCycle();
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rdy, vecs[i].op);
         checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctl, vecs[i].cnt,
                     vecs[i].flt, vecs[i].code);
         nextCycle();
      end

      runFetchTimeout(L);
      runFetchTimeout(H);

      // Reset pulse in MEM_RD: immediate IDLE, no retire, clean restart.
      doReset();
      applyStimulus(H, OP_LW);
      checkOutput("rst idle", 4'd0, C_ZERO, '0, L, 2'b00);
      nextCycle();
      applyStimulus(H, OP_LW);
      nextCycle();
      applyStimulus(H, OP_LW);
      nextCycle();
      applyStimulus(H, OP_LW);
      checkOutput("rst maddr", 4'd3, C_MADDR, '0, L, 2'b00);
      nextCycle();
      applyStimulus(H, OP_LW);
      checkOutput("rst memrd", 4'd4, C_MRD, '0, L, 2'b00);
      rst_n = 1'b0;
      #1;
      checkOutput("rst async", 4'd0, C_ZERO, '0, L, 2'b00);
      @(posedge clk);
      #1;
      checkOutput("rst held", 4'd0, C_ZERO, '0, L, 2'b00);
      nextCycle();
      rst_n = 1'b1;
      applyStimulus(H, OP_LW);
      checkOutput("rst release", 4'd0, C_ZERO, '0, L, 2'b00);
      nextCycle();
      applyStimulus(H, OP_LW);
      checkOutput("rst refetch", 4'd1, C_FETCH_R, '0, L, 2'b00);

      // Eight jumps wrap the 3-bit retire counter back to zero.
      doReset();
      applyStimulus(H, OP_J);
      nextCycle();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(H, OP_J);
         checkOutput($sformatf("wrap fetch%0d", i), 4'd1, C_FETCH_R, CNT_W'(i), L, 2'b00);
         nextCycle();
         applyStimulus(H, OP_J);
         nextCycle();
         applyStimulus(H, OP_J);
         checkOutput($sformatf("wrap jump%0d", i), 4'd10, C_JMP, CNT_W'(i), L, 2'b00);
         nextCycle();
      end
      applyStimulus(H, OP_J);
      checkOutput("wrap zero", 4'd1, C_FETCH_R, '0, L, 2'b00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle sequencing controller for the MIPS datapath. It replaces the single-cycle opcode decode with a Moore/Mealy FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath mux select and strobe, and stalls on a memory ready handshake. It also flags illegal opcodes and memory timeouts, and counts retired instructions.

## Interface
- `TIMEOUT`, default 15: consecutive `mem_ready`-low cycles tolerated in one memory state; 0 disables the timeout.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: `IR[31:26]`, sampled in DECODE.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `ir_write` out 1: PC/IR load enables.
- `i_or_d`, `mem_read`, `mem_write` out 1: memory address select and strobes.
- `reg_dst`, `reg_write`, `mem_to_reg` out 1: register-file controls.
- `alu_src_a` out 1: ALU operand A select (0=PC, 1=rs).
- `alu_src_b` out 2: ALU operand B select (00=rt, 01=4, 10=sext imm, 11=sext imm<<2).
- `alu_op` out 2: ALU operation (00=add, 01=sub, 10=funct).
- `pc_source` out 2: PC source select (00=ALU, 01=ALUOut, 10=jump target).
- `state` out 4: current FSM state encoding.
- `instr_done` out 1: one-cycle retire pulse.
- `retire_cnt` out `CNT_W`: retired instructions, wraps modulo 2^`CNT_W`.
- `fault` out 1: sticky fault flag.
- `fault_code` out 2: 01=illegal opcode, 10=memory timeout.

## Operation
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC 7, ALU_WB 8, BRANCH 9, JUMP 10, FAULT 15. Unused encodings go to FAULT with `fault_code`=01.
- Outputs per state. Any output not listed is 0 in that state.
  - FETCH: `mem_read`=1, `alu_src_b`=01. `ir_write` and `pc_write` both equal `mem_ready`.
  - DECODE: `alu_src_b`=11.
  - MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10.
  - MEM_RD: `mem_read`=1, `i_or_d`=1.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1.
  - MEM_WR: `mem_write`=1, `i_or_d`=1.
  - EXEC: `alu_src_a`=1, `alu_op`=10.
  - ALU_WB: `reg_write`=1, `reg_dst`=1.
  - BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01.
  - JUMP: `pc_write`=1, `pc_source`=10.
- Transitions:
  - IDLE → FETCH unconditionally.
  - FETCH → DECODE on `mem_ready`, else stay.
  - DECODE dispatches on `opcode`:
    - 100011 (lw) or 101011 (sw) → MEM_ADDR.
    - 000000 (R-type) → EXEC.
    - 000100 (beq) → BRANCH.
    - 000010 (j) → JUMP.
    - anything else → FAULT with `fault_code`=01.
  - MEM_ADDR → MEM_RD for lw, → MEM_WR for sw. The opcode is latched in DECODE.
  - MEM_RD → MEM_WB on `mem_ready`.
  - MEM_WR → FETCH on `mem_ready`.
  - MEM_WB, ALU_WB, BRANCH and JUMP → FETCH.
  - EXEC → ALU_WB.
  - FAULT has no exit; only `rst_n` leaves it.
- Retire:
  - `instr_done`=1 in MEM_WB, ALU_WB, BRANCH and JUMP, and in MEM_WR when `mem_ready`=1.
  - `retire_cnt` increments on the same edge.
- Timeout:
  - `wait_cnt` clears on entry to FETCH, MEM_RD or MEM_WR.
  - It increments each cycle spent in one of those states with `mem_ready`=0.
  - When `TIMEOUT`≠0 and the `TIMEOUT`-th consecutive low cycle occurs, the next state is FAULT and `fault_code`=10.
  - `mem_ready`=1 on that same cycle takes precedence: the access completes and no fault is raised.
- In FAULT, all strobes are 0, `fault`=1, and `fault_code` holds.

## Timing
- Reset (async assert, `rst_n`=0):
  - `state`=IDLE, all strobes and selects 0.
  - `instr_done`=0, `retire_cnt`=0, `fault`=0, `fault_code`=00, `wait_cnt`=0.
- First FETCH is 1 cycle after `rst_n` deasserts.
- Latency with zero wait states, counting FETCH through retire:
  - lw 5 cycles, sw 4, R-type 4, beq 3, j 3.
  - Each memory wait cycle adds 1.
- Mealy outputs (`ir_write`, `pc_write` in FETCH; `instr_done` in MEM_WR) are combinational from `mem_ready` within the same cycle.
- All other outputs decode from registered `state` only.
- Reset asserted mid-instruction: immediate return to IDLE; the partial instruction does not retire.
- `retire_cnt` at all-ones plus one retire → 0. No other effect.

## Test plan
- Reset, then `mem_ready` held 1, lw opcode 100011:
  - `state` sequence 0,1,2,3,4,5,1.
  - `instr_done` pulses once, in the MEM_WB cycle; `retire_cnt`=1.
- R-type then beq then j, `mem_ready`=1:
  - `alu_op` is 10 in EXEC and 01 in BRANCH; `pc_source` is 10 in JUMP.
  - `retire_cnt`=3 after 11 cycles.
- sw with `mem_ready` low 3 cycles in MEM_WR (`TIMEOUT`=15):
  - `mem_write` is held 4 cycles; `instr_done` fires only on the ready cycle.
- Opcode 001000 in DECODE → FAULT, `fault`=1, `fault_code`=01, all strobes 0.
  - Remains there until `rst_n`=0.
- `mem_ready` held 0 in FETCH, `TIMEOUT`=15:
  - FAULT is entered after 15 cycles, `fault_code`=10.
  - Repeat with `mem_ready`=1 on cycle 15 → DECODE, no fault.
- `rst_n` pulsed low during MEM_RD:
  - `state`=IDLE immediately; `retire_cnt` unchanged-to-0 and no `instr_done`.
